// File: rtl/maj_fold_sched.sv
// Folded majority scheduler: one shared W-bit popcount slice walks the N-bit vote
// vector chunk by chunk and stops as soon as the majority outcome is decided.
module maj_fold_sched #(
  parameter int unsigned N      = 55,
  parameter int unsigned W      = 8,
  parameter int unsigned THRESH = (N + 1) / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0]                    x,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            y,
  output logic [$clog2(N+1)-1:0]          ones,
  output logic [$clog2((N+W-1)/W+1)-1:0]  chunks
);

  localparam int unsigned NCH    = (N + W - 1) / W;
  localparam int unsigned CW     = $clog2(N + 1);
  localparam int unsigned IW     = $clog2(NCH + 1);
  localparam int unsigned PW     = NCH * W;
  localparam int unsigned LAST_W = N - (NCH - 1) * W;
  localparam logic [CW:0] THR    = (CW+1)'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   acc_q, acc_d, rem_q, rem_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            y_q, y_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [IW-1:0]   chunks_q, chunks_d;

  logic [W-1:0]    chunk_bits;
  logic [CW-1:0]   c, valid_bits, acc_n, rem_n;
  logic [CW:0]     reach_n;
  logic [IW-1:0]   idx_n;

  // The shadow is zero-padded above bit N-1, so the last chunk's upper bits count as 0.
  always_comb begin
    chunk_bits = shadow_q[idx_q*W +: W];
    c          = '0;
    for (int i = 0; i < int'(W); i++) c = c + CW'(chunk_bits[i]);
    valid_bits = (idx_q == IW'(NCH - 1)) ? CW'(LAST_W) : CW'(W);
    acc_n      = acc_q + c;
    rem_n      = rem_q - valid_bits;
    reach_n    = {1'b0, acc_n} + {1'b0, rem_n};
    idx_n      = idx_q + IW'(1);
  end

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    y_d      = y_q;
    ones_d   = ones_q;
    chunks_d = chunks_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shadow_d = PW'(x);
          acc_d    = '0;
          rem_d    = CW'(N);
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = acc_n;
        rem_d = rem_n;
        idx_d = idx_n;
        if ({1'b0, acc_n} >= THR) begin
          y_d      = 1'b1;
          ones_d   = acc_n;
          chunks_d = idx_n;
          state_d  = DONE;
        end else if (reach_n < THR) begin
          y_d      = 1'b0;
          ones_d   = acc_n;
          chunks_d = idx_n;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the shadow is reset too, so a stale vector never leaks into a run after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      y_q      <= 1'b0;
      ones_q   <= '0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      y_q      <= y_d;
      ones_q   <= ones_d;
      chunks_q <= chunks_d;
    end
  end

  // Handshake flags decode the state directly, so reset drops out_valid asynchronously.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign ones      = ones_q;
  assign chunks    = chunks_q;

endmodule
